// File: rtl/conv_ch_accumulator.sv
// conv_ch_accumulator: sums per-input-channel partial-sum ofmap streams into an
// on-chip buffer over a runtime channel count, then drains the final sums
// (optionally through ReLU) on a valid/ready stream with a last flag.
module conv_ch_accumulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int BUFFER_SIZE = 512,
  parameter int MAX_CH      = 8,
  localparam int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(MAX_CH) + 1,
  localparam int LEN_W      = $clog2(BUFFER_SIZE) + 1,
  localparam int CH_W       = $clog2(MAX_CH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        cfg_len,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_relu,
  input  logic                    psum_valid,
  output logic                    psum_ready,
  input  logic [2*DATA_WIDTH-1:0] psum_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err
);

  localparam int IDX_W = (LEN_W > 1) ? LEN_W - 1 : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                  state;
  logic [LEN_W-1:0]        idx;
  logic [CH_W-1:0]         ch_cnt;
  logic [LEN_W-1:0]        len_r;
  logic [CH_W-1:0]         ch_r;
  logic                    relu_r;

  logic signed [ACC_WIDTH-1:0] acc_mem [BUFFER_SIZE];

  logic [IDX_W-1:0]            idx_a;
  logic signed [ACC_WIDTH-1:0] rd_val;
  logic signed [ACC_WIDTH-1:0] psum_ext;
  logic signed [ACC_WIDTH-1:0] wr_val;
  logic                        psum_fire;
  logic                        out_fire;
  logic                        last_elem;
  logic                        last_ch;
  logic                        cfg_bad;

  // Clamp negative sums to zero when ReLU is enabled for the job.
  function automatic logic signed [ACC_WIDTH-1:0] relu_fn(
    input logic signed [ACC_WIDTH-1:0] v,
    input logic                        en
  );
    relu_fn = (en && v < 0) ? '0 : v;
  endfunction

  assign idx_a    = idx[IDX_W-1:0];
  assign rd_val   = acc_mem[idx_a];
  assign psum_ext = {{(ACC_WIDTH-2*DATA_WIDTH){psum_data[2*DATA_WIDTH-1]}}, psum_data};
  // Channel 0 overwrites, so stale contents from an aborted job never leak in.
  assign wr_val   = (ch_cnt == '0) ? psum_ext : rd_val + psum_ext;

  assign psum_ready = (state == ACCUM);
  assign out_valid  = (state == DRAIN);
  assign busy       = (state != IDLE);
  assign last_elem  = (idx == len_r - LEN_W'(1));
  assign last_ch    = (ch_cnt == ch_r - CH_W'(1));
  assign out_last   = out_valid && last_elem;
  assign out_data   = out_valid ? relu_fn(rd_val, relu_r) : '0;
  assign psum_fire  = psum_valid && psum_ready;
  assign out_fire   = out_valid && out_ready;

  assign cfg_bad = (cfg_len == '0) || (cfg_len > LEN_W'(BUFFER_SIZE)) ||
                   (cfg_ch == '0)  || (cfg_ch > CH_W'(MAX_CH));

  // Read-modify-write of one buffer entry per accepted partial sum.
  always_ff @(posedge clk) begin
    if (psum_fire) acc_mem[idx_a] <= wr_val;
  end

  // Job FSM: config latch, element/channel counting, drain sequencing, pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      ch_cnt  <= '0;
      len_r   <= '0;
      ch_r    <= '0;
      relu_r  <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end else begin
              len_r  <= cfg_len;
              ch_r   <= cfg_ch;
              relu_r <= cfg_relu;
              idx    <= '0;
              ch_cnt <= '0;
              state  <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (psum_fire) begin
            if (last_elem) begin
              idx <= '0;
              if (last_ch) begin
                ch_cnt <= '0;
                state  <= DRAIN;
              end else begin
                ch_cnt <= ch_cnt + CH_W'(1);
              end
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (last_elem) begin
              idx   <= '0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              idx <= idx + LEN_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_ch_accumulator.sv
// Scoreboard bench for conv_ch_accumulator: stimulus pushes expected final sums
// computed from per-channel arrays; a negedge monitor pops on each output beat.
module tb_conv_ch_accumulator;

  localparam int DW    = 16;
  localparam int BS    = 512;
  localparam int MC    = 8;
  localparam int ACC_W = 2*DW + $clog2(MC) + 1;
  localparam int LEN_W = $clog2(BS) + 1;
  localparam int CH_W  = $clog2(MC) + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  cfg_len;
  logic [CH_W-1:0]   cfg_ch;
  logic              cfg_relu;
  logic              psum_valid;
  logic              psum_ready;
  logic [2*DW-1:0]   psum_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              cfg_err;

  conv_ch_accumulator #(.DATA_WIDTH(DW), .BUFFER_SIZE(BS), .MAX_CH(MC)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_ch(cfg_ch),
    .cfg_relu(cfg_relu), .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum_data(psum_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done),
    .cfg_err(cfg_err)
  );

  typedef struct {
    longint d;
    bit     l;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  longint ps [MC][BS];
  int     n_cmp = 0;
  int     n_err = 0;
  int     done_cnt = 0;
  int     jobs = 0;
  int     rdy_mode = 0;
  int     pcnt = 0;
  bit     held_v = 0;
  longint held_d;
  bit     held_l;
  bit     rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint out_s();
    return longint'($signed(out_data));
  endfunction

  // out_ready driver: always ready, fixed 1,0,0,1 pattern, or random.
  initial begin
    out_ready = 1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: begin out_ready = rdy_pat[pcnt % 4]; pcnt++; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1;
      endcase
    end
  end

  // Monitor: scoreboard pop on handshake, stall stability, drain/accum exclusion.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 0;
    end else begin
      if (done) done_cnt++;
      if (held_v && out_valid) begin
        chk("stall_data_stable", out_s(), held_d);
        chk("stall_last_stable", longint'(out_last), longint'(held_l));
      end
      held_v = out_valid && !out_ready;
      held_d = out_s();
      held_l = out_last;
      if (out_valid) chk("psum_ready_in_drain", longint'(psum_ready), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", out_s(), mon_e.d);
          chk("out_last", longint'(out_last), longint'(mon_e.l));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_job(input int len, input int ch, input bit relu,
                         input bit gaps, input int mode);
    longint s;
    int     t;
    exp_t   e;
    for (int i = 0; i < len; i++) begin
      s = 0;
      for (int c = 0; c < ch; c++) s += ps[c][i];
      if (relu && s < 0) s = 0;
      e.d = s;
      e.l = (i == len - 1);
      exp_q.push_back(e);
    end
    rdy_mode = mode;
    start    = 1;
    cfg_len  = LEN_W'(len);
    cfg_ch   = CH_W'(ch);
    cfg_relu = relu;
    tick();
    start = 0;
    chk("busy_after_start", longint'(busy), 1);
    for (int c = 0; c < ch; c++) begin
      for (int i = 0; i < len; i++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          psum_valid = 0;
          repeat ($urandom_range(1, 3)) tick();
        end
        psum_valid = 1;
        psum_data  = 32'(ps[c][i]);
        t = 0;
        while (!psum_ready && t < 100) begin
          tick();
          t++;
        end
        if (!psum_ready) begin
          chk("psum_ready_timeout", 0, 1);
          psum_valid = 0;
          return;
        end
        tick();
      end
    end
    psum_valid = 0;
    chk("out_valid_latency", longint'(out_valid), 1);
    t = 0;
    while (!done && t < 5000) begin
      tick();
      t++;
    end
    chk("done_seen", longint'(done), 1);
    chk("busy_after_done", longint'(busy), 0);
    jobs++;
    tick();
    chk("done_pulse_count", done_cnt, jobs);
    chk("queue_drained", exp_q.size(), 0);
    rdy_mode = 0;
  endtask

  task automatic bad_cfg(input int len, input int ch);
    start    = 1;
    cfg_len  = LEN_W'(len);
    cfg_ch   = CH_W'(ch);
    cfg_relu = 0;
    tick();
    start = 0;
    chk("cfg_err_pulse", longint'(cfg_err), 1);
    chk("cfg_err_busy_low", longint'(busy), 0);
    tick();
    chk("cfg_err_one_cycle", longint'(cfg_err), 0);
  endtask

  initial begin
    rst = 1; start = 0; cfg_len = 0; cfg_ch = 0; cfg_relu = 0;
    psum_valid = 0; psum_data = 0;
    repeat (3) tick();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_psum_ready", longint'(psum_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_cfg_err", longint'(cfg_err), 0);
    chk("rst_out_data", out_s(), 0);
    rst = 0;
    tick();

    // Single channel
    for (int i = 0; i < 4; i++) ps[0][i] = i + 1;
    run_job(4, 1, 0, 0, 0);

    // Multi-channel
    ps[0][0] = 1;  ps[0][1] = 2;  ps[0][2] = 3;
    ps[1][0] = 10; ps[1][1] = 20; ps[1][2] = 30;
    ps[2][0] = -5; ps[2][1] = -5; ps[2][2] = -5;
    run_job(3, 3, 0, 0, 0);

    // ReLU on and off
    ps[0][0] = -10; ps[0][1] = 5;
    ps[1][0] = 3;   ps[1][1] = -8;
    run_job(2, 2, 1, 0, 0);
    run_job(2, 2, 0, 0, 0);

    // Backpressure 1,0,0,1 plus input gaps
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < 6; i++) ps[c][i] = longint'($signed(32'($urandom)));
    run_job(6, 3, 0, 1, 1);

    // Full-scale positive and negative sums over MAX_CH channels
    for (int c = 0; c < MC; c++)
      for (int i = 0; i < 4; i++) ps[c][i] = 64'sd2147483647;
    run_job(4, MC, 0, 0, 0);
    for (int c = 0; c < MC; c++)
      for (int i = 0; i < 4; i++) ps[c][i] = -64'sd2147483648;
    run_job(4, MC, 1, 0, 0);
    for (int c = 0; c < MC; c++)
      for (int i = 0; i < 4; i++) ps[c][i] = -64'sd2147483648;
    run_job(4, MC, 0, 0, 1);

    // Invalid configurations
    bad_cfg(0, 1);
    bad_cfg(BS + 1, 1);
    bad_cfg(4, 0);
    bad_cfg(4, MC + 1);

    // Abort a job with reset after two beats; start while busy is ignored
    start = 1; cfg_len = 3; cfg_ch = 2; cfg_relu = 0;
    tick();
    start = 0;
    psum_valid = 1; psum_data = 32'd100;
    tick();
    psum_data = 32'd200;
    start = 1; cfg_len = 0;
    tick();
    start = 0; psum_valid = 0;
    chk("start_while_busy_no_err", longint'(cfg_err), 0);
    chk("start_while_busy_still_busy", longint'(busy), 1);
    rst = 1;
    tick();
    rst = 0;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_psum_ready", longint'(psum_ready), 0);
    chk("midrst_out_valid", longint'(out_valid), 0);
    ps[0][0] = 7; ps[0][1] = 8; ps[0][2] = 9;
    run_job(3, 1, 0, 0, 0);

    // Randomized jobs
    for (int j = 0; j < 6; j++) begin
      int len;
      int ch;
      len = $urandom_range(1, 12);
      ch  = $urandom_range(1, MC);
      for (int c = 0; c < ch; c++)
        for (int i = 0; i < len; i++) ps[c][i] = longint'($signed(32'($urandom)));
      run_job(len, ch, 1'($urandom_range(0, 1)), 1, 2);
    end

    // Full buffer depth
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < BS; i++) ps[c][i] = longint'($signed(32'($urandom)));
    run_job(BS, 2, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_ch_accumulator.md
Name: conv_ch_accumulator

Overview:
- Parametrised successor stage to the convolution top level. It receives per-input-channel partial-sum ofmap streams from the PE array and accumulates them over a runtime-configurable channel count in an on-chip buffer.
- Once all channels have been accumulated, it drains the final sums, with optional ReLU, over a valid/ready stream with a last flag.
- It sits between the conv operator's ofmap output and the output writeback path.

Parameters:
- DATA_WIDTH, 16, operand width; partial sums are 2*DATA_WIDTH signed.
- BUFFER_SIZE, 512, maximum ofmap elements per job (buffer depth).
- MAX_CH, 8, maximum input channels accumulated per job (>=1).
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(MAX_CH)+1, signed accumulator and output width (derived; not overridden).

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  one-cycle job start pulse; sampled only in IDLE.
- cfg_len  input  $clog2(BUFFER_SIZE)+1  ofmap elements per channel, valid range 1..BUFFER_SIZE.
- cfg_ch  input  $clog2(MAX_CH)+1  channels to accumulate, valid range 1..MAX_CH.
- cfg_relu  input  1  applies ReLU on drain when 1.
- psum_valid  input  1  partial-sum beat valid.
- psum_ready  output  1  accumulator can accept a beat.
- psum_data  input  2*DATA_WIDTH  signed partial sum.
- out_valid  output  1  final-sum beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  ACC_WIDTH  signed final sum.
- out_last  output  1  marks the final element of the job.
- busy  output  1  high in ACCUM or DRAIN.
- done  output  1  one-cycle pulse after the last output handshake.
- cfg_err  output  1  one-cycle pulse when start carries an invalid config.

Behaviour:
- Reset (synchronous, rst=1 at an edge): state=IDLE, counters=0. psum_ready, out_valid, out_last, busy, done and cfg_err are all 0, and out_data=0. Buffer contents are not cleared.
- Buffer: BUFFER_SIZE x ACC_WIDTH array with asynchronous read and synchronous write. A single-cycle read-modify-write supports one beat per cycle with no bubbles.
- IDLE:
  - psum_ready=0 and out_valid=0; psum beats are ignored.
  - start with a valid config latches len/ch/relu, clears idx and ch_cnt, and moves to ACCUM next cycle.
  - start with cfg_len=0, cfg_len>BUFFER_SIZE, cfg_ch=0 or cfg_ch>MAX_CH pulses cfg_err for 1 cycle and stays in IDLE.
- ACCUM:
  - psum_ready=1 and busy=1.
  - Handshake (psum_valid && psum_ready):
    - ch_cnt==0: buf[idx] <= sign_extend(psum_data).
    - otherwise: buf[idx] <= buf[idx] + sign_extend(psum_data).
  - idx increments per beat. When idx==len-1, idx wraps to 0 and ch_cnt increments.
  - Accepting idx==len-1 with ch_cnt==ch-1 moves to DRAIN next cycle, with idx=0.
  - Gaps in psum_valid only stall progress; no state change.
- DRAIN:
  - psum_ready=0, out_valid=1, out_last=(idx==len-1).
  - out_data = (relu && buf[idx]<0) ? 0 : buf[idx].
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - Each handshake increments idx.
  - The handshake with out_last=1 moves to IDLE; done pulses in the following cycle and busy falls.
- Latency: if the final psum is accepted at edge N, out_valid=1 in the cycle after edge N. The first output handshake is possible at edge N+1.
- Overflow: ACC_WIDTH guarantees no wrap for MAX_CH full-scale sums of either sign; no saturation logic.
- start asserted while busy: ignored, with no cfg_err.
- rst mid-ACCUM or mid-DRAIN: immediate return to IDLE per the reset values. The next job overwrites stale buffer entries on channel 0, so it produces correct results.
- Back-to-back jobs: start in the same cycle done=1 is accepted because state is already IDLE.

Test Plan:
- Single channel: len=4, ch=1, relu=0, psums 1,2,3,4 -> out 1,2,3,4; out_last only on 4; done pulses once; busy low afterwards.
- Multi-channel: len=3, ch=3, psums (1,2,3),(10,20,30),(-5,-5,-5) -> out 6,17,28.
- ReLU: len=2, ch=2, psums (-10,5),(3,-8) -> relu=1 out 0,0; relu=0 out -7,-3.
- Backpressure and gaps: random psum_valid gaps plus out_ready toggling 1,0,0,1 -> out_data/out_last stable while stalled, no lost or duplicated beats, psum_ready=0 throughout DRAIN.
- Width corner: ch=MAX_CH=8, all psums 0x7FFFFFFF -> out 8*(2^31-1)=17179869176; all psums 0x80000000 -> out -17179869184.
- Error and reset: start with cfg_len=0 -> cfg_err pulse, busy stays 0. Then rst after 2 beats of a len=3, ch=2 job, then a new job len=3, ch=1 with psums 7,8,9 -> out 7,8,9 with no stale sums.
